// File: rtl/clock_time_core.sv
// -----------------------------------------------------------------------------
// clock_time_core
//   24-hour BCD time-of-day core. A 16-bit prescaler divides the system clock
//   down to a one-second tick, which advances seconds/minutes/hours with full
//   BCD carry resolution in a single edge. Two asynchronous pushbuttons set the
//   minutes and hours; each is synchronized and edge-detected so that a held
//   button produces exactly one update.
//
// Parameters
//   TICK_DIV  : clock cycles per one-second tick (2..65536)
//
// Ports
//   clock     : in  system clock, rising-edge active
//   reset     : in  asynchronous active-low reset
//   run_en    : in  prescaler advances while high; time holds while low
//   set_min   : in  asynchronous pushbutton, rising edge advances minutes
//   set_hour  : in  asynchronous pushbutton, rising edge advances hours
//   sec_bcd   : out seconds 00..59, BCD, tens digit in [7:4]
//   min_bcd   : out minutes 00..59, BCD
//   hour_bcd  : out hours 00..23, BCD
//   sec_tick  : out one-cycle pulse coincident with a new seconds value
//   day_wrap  : out one-cycle pulse coincident with the 23:59:59 -> 00:00:00 roll
// -----------------------------------------------------------------------------
module clock_time_core #(
  parameter int TICK_DIV = 65536
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run_en,
  input  logic       set_min,
  input  logic       set_hour,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       sec_tick,
  output logic       day_wrap
);

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [7:0]  sec_q, sec_d;
  logic [7:0]  min_q, min_d;
  logic [7:0]  hour_q, hour_d;
  logic        sec_tick_q, sec_tick_d;
  logic        day_wrap_q, day_wrap_d;

  logic [1:0]  min_sync_q, hour_sync_q;
  logic        min_prev_q, hour_prev_q;

  logic        tick;
  logic        min_evt, hour_evt;

  // Two-digit BCD increment that wraps to 00 after 'last'.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v == last) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'h0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // The edge detector compares the second synchronizer flop with its own
  // registered copy, so an event fires on the edge after the button reaches
  // the second flop: sampled at edge N, applied at edge N+2.
  assign min_evt  = min_sync_q[1]  & ~min_prev_q;
  assign hour_evt = hour_sync_q[1] & ~hour_prev_q;
  assign tick     = run_en && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d    = presc_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;

    // Prescaler runs independently of set events, so it still wraps on a
    // dropped tick and the next tick stays on its regular cadence.
    if (run_en) begin
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end

    if (min_evt || hour_evt) begin
      // Set events win over a coincident tick; no pulses are emitted.
      sec_d = 8'h00;
      if (min_evt)  min_d  = bcd_inc(min_q, 8'h59);
      if (hour_evt) hour_d = bcd_inc(hour_q, 8'h23);
    end else if (tick) begin
      sec_tick_d = 1'b1;
      day_wrap_d = (hour_q == 8'h23) && (min_q == 8'h59) && (sec_q == 8'h59);
      sec_d      = bcd_inc(sec_q, 8'h59);
      if (sec_q == 8'h59) begin
        min_d = bcd_inc(min_q, 8'h59);
        if (min_q == 8'h59) begin
          hour_d = bcd_inc(hour_q, 8'h23);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q     <= 16'd0;
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      hour_q      <= 8'h00;
      sec_tick_q  <= 1'b0;
      day_wrap_q  <= 1'b0;
      min_sync_q  <= 2'b00;
      hour_sync_q <= 2'b00;
      min_prev_q  <= 1'b0;
      hour_prev_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      sec_tick_q  <= sec_tick_d;
      day_wrap_q  <= day_wrap_d;
      min_sync_q  <= {min_sync_q[0], set_min};
      hour_sync_q <= {hour_sync_q[0], set_hour};
      min_prev_q  <= min_sync_q[1];
      hour_prev_q <= hour_sync_q[1];
    end
  end

  assign sec_bcd  = sec_q;
  assign min_bcd  = min_q;
  assign hour_bcd = hour_q;
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;

endmodule

// File: tb/tb_clock_time_core.sv
module tb_clock_time_core;

  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       run_en = 1'b0;
  logic       set_min = 1'b0;
  logic       set_hour = 1'b0;
  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic       sec_tick, day_wrap;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  clock_time_core #(.TICK_DIV(TD)) dut (
    .clock    (clock),
    .reset    (reset),
    .run_en   (run_en),
    .set_min  (set_min),
    .set_hour (set_hour),
    .sec_bcd  (sec_bcd),
    .min_bcd  (min_bcd),
    .hour_bcd (hour_bcd),
    .sec_tick (sec_tick),
    .day_wrap (day_wrap)
  );

  // Reference model: time of day as plain integers, seconds-of-day arithmetic.
  int   m_s, m_m, m_h, m_p;
  bit   m_stick, m_dwrap;
  bit [2:0] hm, hh;   // button samples from the last three edges
  int   n_s, n_m, n_h, n_p, tod;
  bit   n_stick, n_dwrap, em, eh, tk;

  always_comb begin
    em = hm[1] && !hm[2];
    eh = hh[1] && !hh[2];
    tk = run_en && (m_p == TD - 1);
    n_p = run_en ? (m_p + 1) % TD : m_p;
    n_s = m_s; n_m = m_m; n_h = m_h;
    n_stick = 1'b0; n_dwrap = 1'b0; tod = 0;
    if (em || eh) begin
      n_s = 0;
      if (em) n_m = (m_m + 1) % 60;
      if (eh) n_h = (m_h + 1) % 24;
    end else if (tk) begin
      n_stick = 1'b1;
      n_dwrap = (m_h * 3600 + m_m * 60 + m_s) == 86399;
      tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
      n_h = tod / 3600;
      n_m = (tod / 60) % 60;
      n_s = tod % 60;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_s <= 0; m_m <= 0; m_h <= 0; m_p <= 0;
      m_stick <= 1'b0; m_dwrap <= 1'b0; hm <= 3'b000; hh <= 3'b000;
    end else begin
      m_s <= n_s; m_m <= n_m; m_h <= n_h; m_p <= n_p;
      m_stick <= n_stick; m_dwrap <= n_dwrap;
      hm <= {hm[1:0], set_min};
      hh <= {hh[1:0], set_hour};
    end
  end

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r = 8'(((v / 10) << 4) | (v % 10));
    return r;
  endfunction

  // One pushbutton pulse; returns after the update is visible.
  task automatic press(input bit hour_btn);
    @(negedge clock);
    if (hour_btn) set_hour = 1'b1; else set_min = 1'b1;
    @(negedge clock);
    set_hour = 1'b0; set_min = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_cmp++; if (sec_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_sec: got %h expected 00", sec_bcd); end
    n_cmp++; if (min_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_min: got %h expected 00", min_bcd); end
    n_cmp++; if (hour_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_hour: got %h expected 00", hour_bcd); end
    n_cmp++; if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", sec_tick); end
    n_cmp++; if (day_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", day_wrap); end
  endtask

  task automatic test_first_tick();
    reset = 1'b1;
    run_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (k < 4) begin
        n_cmp++; if (sec_bcd !== 8'h00 || sec_tick !== 1'b0) begin
          n_fail++; $display("FAIL first_tick_early e%0d: got sec=%h tick=%b expected 00/0", k, sec_bcd, sec_tick); end
      end else if (k == 4) begin
        n_cmp++; if (sec_bcd !== 8'h01 || sec_tick !== 1'b1) begin
          n_fail++; $display("FAIL first_tick e4: got sec=%h tick=%b expected 01/1", sec_bcd, sec_tick); end
      end else if (k == 5) begin
        n_cmp++; if (sec_bcd !== 8'h01 || sec_tick !== 1'b0) begin
          n_fail++; $display("FAIL first_tick e5: got sec=%h tick=%b expected 01/0", sec_bcd, sec_tick); end
      end else if (k == 8) begin
        n_cmp++; if (sec_bcd !== 8'h02 || sec_tick !== 1'b1) begin
          n_fail++; $display("FAIL second_tick e8: got sec=%h tick=%b expected 02/1", sec_bcd, sec_tick); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      n_cmp++;
      if (sec_bcd !== bcd(m_s) || min_bcd !== bcd(m_m) || hour_bcd !== bcd(m_h) ||
          sec_tick !== m_stick || day_wrap !== m_dwrap) begin
        n_fail++;
        $display("FAIL random c%0d: got %h:%h:%h t=%b w=%b expected %h:%h:%h t=%b w=%b", c,
                 hour_bcd, min_bcd, sec_bcd, sec_tick, day_wrap,
                 bcd(m_h), bcd(m_m), bcd(m_s), m_stick, m_dwrap);
      end
      run_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) set_min = ~set_min;
      if ($urandom_range(0, 7) == 0) set_hour = ~set_hour;
    end
    set_min = 1'b0; set_hour = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_day_wrap();
    int np;
    bit found;
    run_en = 1'b0;
    repeat (2) @(negedge clock);
    np = (23 - m_h + 24) % 24;
    for (int i = 0; i < np; i++) press(1'b1);
    np = (58 - m_m + 60) % 60;
    for (int i = 0; i < np; i++) press(1'b0);
    press(1'b0);
    run_en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clock);
      if (m_h == 23 && m_m == 59 && m_s == 59) found = 1'b1;
    end
    n_cmp++;
    if (!found || hour_bcd !== 8'h23 || min_bcd !== 8'h59 || sec_bcd !== 8'h59) begin
      n_fail++; $display("FAIL preload_235959: got %h:%h:%h reached=%b expected 23:59:59", hour_bcd, min_bcd, sec_bcd, found);
    end
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clock);
      if (m_stick) found = 1'b1;
    end
    n_cmp++;
    if (!found || hour_bcd !== 8'h00 || min_bcd !== 8'h00 || sec_bcd !== 8'h00 ||
        day_wrap !== 1'b1 || sec_tick !== 1'b1) begin
      n_fail++; $display("FAIL day_wrap: got %h:%h:%h w=%b t=%b expected 00:00:00 w=1 t=1",
                         hour_bcd, min_bcd, sec_bcd, day_wrap, sec_tick);
    end
    @(negedge clock);
    n_cmp++;
    if (day_wrap !== 1'b0 || sec_tick !== 1'b0) begin
      n_fail++; $display("FAIL day_wrap_width: got w=%b t=%b expected 0/0", day_wrap, sec_tick);
    end
  endtask

  task automatic test_hold_no_repeat();
    int np;
    run_en = 1'b0;
    repeat (2) @(negedge clock);
    np = (24 - m_h) % 24;
    for (int i = 0; i < np; i++) press(1'b1);
    np = (59 - m_m + 60) % 60;
    for (int i = 0; i < np; i++) press(1'b0);
    set_min = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k <= 2) begin
        n_cmp++; if (min_bcd !== 8'h59) begin
          n_fail++; $display("FAIL hold_early k%0d: got min=%h expected 59", k, min_bcd); end
      end else begin
        n_cmp++; if (min_bcd !== 8'h00 || hour_bcd !== 8'h00 || sec_bcd !== 8'h00) begin
          n_fail++; $display("FAIL hold_once k%0d: got %h:%h:%h expected 00:00:00", k, hour_bcd, min_bcd, sec_bcd); end
      end
    end
    set_min = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_set_hour_wrap();
    int np, exp_m;
    bit found;
    run_en = 1'b0;
    np = (23 - m_h + 24) % 24;
    for (int i = 0; i < np; i++) press(1'b1);
    run_en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clock);
      if (m_s != 0) found = 1'b1;
    end
    run_en = 1'b0;
    exp_m = m_m;
    press(1'b1);
    n_cmp++;
    if (!found || hour_bcd !== 8'h00 || sec_bcd !== 8'h00 || min_bcd !== bcd(exp_m)) begin
      n_fail++; $display("FAIL set_hour_wrap: got %h:%h:%h expected 00:%h:00", hour_bcd, min_bcd, sec_bcd, bcd(exp_m));
    end
  endtask

  task automatic test_set_on_tick();
    int exp_m;
    bit found;
    run_en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clock);
      if (m_p == 0) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL align_timeout: got none expected prescaler 0"); end
    @(negedge clock);              // after E+1
    set_min = 1'b1;
    exp_m = (m_m + 1) % 60;
    @(negedge clock);              // after E+2, sampled
    set_min = 1'b0;
    @(negedge clock);              // after E+3
    @(negedge clock);              // after E+4, tick edge
    n_cmp++;
    if (sec_bcd !== 8'h00 || min_bcd !== bcd(exp_m) || sec_tick !== 1'b0 || day_wrap !== 1'b0) begin
      n_fail++; $display("FAIL set_over_tick: got min=%h sec=%h t=%b w=%b expected min=%h sec=00 t=0 w=0",
                         min_bcd, sec_bcd, sec_tick, day_wrap, bcd(exp_m));
    end
    for (int j = 5; j <= 8; j++) begin
      @(negedge clock);
      if (j < 8) begin
        n_cmp++; if (sec_tick !== 1'b0) begin
          n_fail++; $display("FAIL early_tick e%0d: got %b expected 0", j, sec_tick); end
      end else begin
        n_cmp++; if (sec_tick !== 1'b1 || sec_bcd !== 8'h01) begin
          n_fail++; $display("FAIL next_tick e8: got t=%b sec=%h expected 1/01", sec_tick, sec_bcd); end
      end
    end
  endtask

  task automatic test_hold_and_reset();
    int fs, fm, fh;
    bit found;
    press(1'b1);
    run_en = 1'b1;
    repeat (6) @(negedge clock);
    run_en = 1'b0;
    fs = m_s; fm = m_m; fh = m_h;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      n_cmp++;
      if (sec_bcd !== bcd(fs) || min_bcd !== bcd(fm) || hour_bcd !== bcd(fh) || sec_tick !== 1'b0) begin
        n_fail++; $display("FAIL frozen k%0d: got %h:%h:%h t=%b expected %h:%h:%h t=0",
                           k, hour_bcd, min_bcd, sec_bcd, sec_tick, bcd(fh), bcd(fm), bcd(fs));
      end
    end
    run_en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clock);
      if (m_stick) found = 1'b1;
    end
    n_cmp++;
    if (!found || sec_tick !== 1'b1 || hour_bcd !== bcd(m_h) || hour_bcd === 8'h00) begin
      n_fail++; $display("FAIL pre_reset: got hour=%h t=%b expected hour=%h t=1", hour_bcd, sec_tick, bcd(m_h));
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (sec_bcd !== 8'h00 || min_bcd !== 8'h00 || hour_bcd !== 8'h00 || sec_tick !== 1'b0 || day_wrap !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got %h:%h:%h t=%b w=%b expected 00:00:00 t=0 w=0",
                         hour_bcd, min_bcd, sec_bcd, sec_tick, day_wrap);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_tick();
    test_random();
    test_day_wrap();
    test_hold_no_repeat();
    test_set_hour_wrap();
    test_set_on_tick();
    test_hold_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
